// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and presents
// fetched words to decode with stall skid, redirect handling and sticky fetch-error trapping.
module instr_fetch_unit #(
    parameter logic [0:31] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    output logic [0:31] imem_address,
    input  logic [0:31] imem_instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [0:31] redirect_pc,
    output logic        if_valid,
    output logic [0:31] if_instruction,
    output logic [0:31] if_pc,
    output logic [0:31] if_pc_plus4,
    output logic        fetch_error,
    output logic [0:31] fetch_count
);

    localparam logic [0:31] LAST_ADDR = 32'(IMEM_BYTES - 4);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [0:31] addr_q, addr_d;
    logic [0:31] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [0:31] skid_instr_q, skid_instr_d;
    logic [0:31] skid_pc_q, skid_pc_d;
    logic        end_q, end_d;
    logic        error_q, error_d;
    logic [0:31] count_q, count_d;
    logic        advance;
    logic        redirect_ok;

    assign redirect_ok = (redirect_pc[30:31] == 2'b00) && (redirect_pc <= LAST_ADDR);

    always_comb begin
        if_valid       = 1'b0;
        if_pc          = pend_pc_q;
        if_instruction = '0;
        case (state_q)
            ST_RUN:  if_valid = pend_valid_q;
            ST_HOLD: begin
                if_valid = 1'b1;
                if_pc    = skid_pc_q;
            end
            default: ;
        endcase
        if (redirect_valid) begin
            if_valid = 1'b0;
        end
        if (if_valid) begin
            if_instruction = (state_q == ST_HOLD) ? skid_instr_q : imem_instruction;
        end
        if_pc_plus4 = if_pc + 32'd4;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        end_d        = end_q;
        error_d      = error_q;
        count_d      = (if_valid && !stall) ? count_q + 32'd1 : count_q;
        advance      = 1'b0;

        case (state_q)
            ST_BOOT: advance = 1'b1;
            ST_RUN: begin
                if (!stall || !pend_valid_q) begin
                    advance = 1'b1;
                end else begin
                    skid_instr_d = imem_instruction;
                    skid_pc_d    = pend_pc_q;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: advance = !stall;
            default: ;
        endcase

        if (advance) begin
            if (end_q) begin
                // The last legal word has just been accepted; there is nothing further to fetch.
                state_d      = ST_ERR;
                pend_valid_d = 1'b0;
                end_d        = 1'b0;
                error_d      = 1'b1;
            end else begin
                state_d      = ST_RUN;
                pend_pc_d    = addr_q;
                pend_valid_d = 1'b1;
                if (addr_q >= LAST_ADDR) begin
                    end_d = 1'b1;
                end else begin
                    addr_d = addr_q + 32'd4;
                end
            end
        end

        if (redirect_valid) begin
            state_d      = redirect_ok ? ST_RUN : ST_ERR;
            addr_d       = (redirect_pc > LAST_ADDR) ? LAST_ADDR : redirect_pc;
            pend_valid_d = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            end_d        = 1'b0;
            error_d      = !redirect_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            addr_q       <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            end_q        <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            end_q        <= end_d;
            error_q      <= error_d;
            count_q      <= count_d;
        end
    end

    assign imem_address = addr_q;
    assign fetch_error  = error_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset-mid-hold sequence, and a random
// phase checked against a delivery-order model of the fetch stream.
module tb_instr_fetch_unit;

    localparam logic [31:0] LAST = 32'd2044;
    localparam logic [31:0] W0 = 32'h014B4820;
    localparam logic [31:0] W1 = 32'h014B4822;
    localparam logic [31:0] W2 = 32'h014B4824;
    localparam logic [31:0] W3 = 32'hC0DE0003;
    localparam logic [31:0] WL = 32'hC0DE01FF;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] imem_address;
    logic [0:31] imem_instruction;
    logic        stall;
    logic        redirect_valid;
    logic [0:31] redirect_pc;
    logic        if_valid;
    logic [0:31] if_instruction;
    logic [0:31] if_pc;
    logic [0:31] if_pc_plus4;
    logic        fetch_error;
    logic [0:31] fetch_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(2048)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .fetch_error     (fetch_error),
        .fetch_count     (fetch_count)
    );

    // Synchronous-read instruction memory: one cycle from address sample to data.
    logic [31:0] mem [512];
    logic [31:0] addr_flat;
    assign addr_flat = imem_address;
    always @(posedge clk) imem_instruction <= mem[addr_flat[10:2]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[10:2]];
    endfunction

    task automatic check_cycle(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [31:0] einstr, input logic eerr,
                               input logic [31:0] ecnt);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, ev});
        chk({tag, ".instr"}, if_instruction, einstr);
        if (ev) begin
            chk({tag, ".pc"}, if_pc, epc);
            chk({tag, ".pc4"}, if_pc_plus4, epc + 32'd4);
        end
        chk({tag, ".err"}, {31'd0, fetch_error}, {31'd0, eerr});
        chk({tag, ".count"}, fetch_count, ecnt);
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        eerr;
        logic [31:0] ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic rv, input logic [31:0] rpc, input logic ev,
                       input logic [31:0] epc, input logic [31:0] ei, input logic ee,
                       input logic [31:0] ec, input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
        v.einstr = ei; v.eerr = ee; v.ecnt = ec; v.eaddr = ea;
        vecs.push_back(v);
    endtask

    // Reference model state for the random phase.
    logic [31:0] m_pc;
    int          m_blank;
    bit          m_err;
    logic [31:0] m_cnt;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = W2;

        // stall rv rpc | valid pc instr err count address
        add(0, 0, 0,    0, 0,    0,  0, 0, 0);
        add(0, 0, 0,    1, 0,    W0, 0, 0, 4);
        add(0, 0, 0,    1, 4,    W1, 0, 1, 8);
        add(0, 0, 0,    1, 8,    W2, 0, 2, 12);
        add(0, 1, 4,    0, 0,    0,  0, 3, 16);
        add(0, 0, 0,    0, 0,    0,  0, 3, 4);
        add(1, 0, 0,    1, 4,    W1, 0, 3, 8);
        add(1, 0, 0,    1, 4,    W1, 0, 3, 8);
        add(1, 0, 0,    1, 4,    W1, 0, 3, 8);
        add(0, 0, 0,    1, 4,    W1, 0, 3, 8);
        add(0, 1, 0,    0, 0,    0,  0, 4, 12);
        add(0, 0, 0,    0, 0,    0,  0, 4, 0);
        add(1, 0, 0,    1, 0,    W0, 0, 4, 4);
        add(1, 1, 8,    0, 0,    0,  0, 4, 4);
        add(0, 0, 0,    0, 0,    0,  0, 4, 8);
        add(0, 0, 0,    1, 8,    W2, 0, 4, 12);
        add(0, 1, 6,    0, 0,    0,  0, 5, 16);
        add(0, 0, 0,    0, 0,    0,  1, 5, 6);
        add(0, 1, LAST, 0, 0,    0,  1, 5, 6);
        add(0, 0, 0,    0, 0,    0,  0, 5, LAST);
        add(0, 0, 0,    1, LAST, WL, 0, 5, LAST);
        add(0, 0, 0,    0, 0,    0,  1, 6, LAST);
        add(0, 0, 0,    0, 0,    0,  1, 6, LAST);

        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle("reset", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        chk("reset.pc", if_pc, 32'd0);
        chk("reset.pc4", if_pc_plus4, 32'd4);
        chk("reset.addr", imem_address, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            check_cycle($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                        vecs[i].eerr, vecs[i].ecnt);
            chk($sformatf("row%0d.addr", i), imem_address, vecs[i].eaddr);
            @(posedge clk);
            #1;
        end

        // Reach HOLD on pc 0, then reset asynchronously in the middle of the cycle.
        stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        stall = 1'b1;
        @(negedge clk);
        check_cycle("hold_a", 1'b1, 32'd0, W0, 1'b0, 32'd6);
        @(posedge clk); #1;
        @(negedge clk);
        check_cycle("hold_b", 1'b1, 32'd0, W0, 1'b0, 32'd6);
        #2 reset = 1'b1;
        #1;
        check_cycle("async_rst", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        chk("async_rst.addr", imem_address, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;

        m_pc = 32'd0; m_blank = 1; m_err = 1'b0; m_cnt = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            logic        ev;
            logic [31:0] rpc;
            int unsigned r;
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 15);
            if (r == 0)      rpc = $urandom;
            else if (r == 1) rpc = 32'($urandom_range(0, 511)) * 4 + 32'd2;
            else if (r < 7)  rpc = LAST - 32'($urandom_range(0, 6)) * 4;
            else             rpc = 32'($urandom_range(0, 511)) * 4;
            redirect_pc = rpc;
            @(negedge clk);
            ev = !m_err && (m_blank == 0) && !redirect_valid;
            check_cycle($sformatf("rnd%0d", n), ev, m_pc, ev ? word_at(m_pc) : 32'd0, m_err,
                        m_cnt);
            if (redirect_valid) begin
                m_pc    = rpc;
                m_blank = 1;
                m_err   = (rpc[1:0] != 2'b00) || (rpc > LAST);
            end else if (ev && !stall) begin
                m_cnt++;
                if (m_pc == LAST) m_err = 1'b1;
                else m_pc = m_pc + 32'd4;
            end else if (!m_err && m_blank > 0) begin
                m_blank--;
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
